// File: rtl/cpu_control_sequencer_pkg.sv
// Shared constants for the SAP-style CPU control sequencer:
// opcodes, control-word bit positions, idle word and T-state encoding.
package cpu_pkg;

  localparam int CTL_W = 15;
  localparam int T_W   = 3;
  localparam int T_NUM = 6;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam int CTL_CP   = 14;
  localparam int CTL_EP   = 13;
  localparam int CTL_LP   = 12;
  localparam int CTL_NLMA = 11;
  localparam int CTL_NLMD = 10;
  localparam int CTL_NCE  = 9;
  localparam int CTL_NLR  = 8;
  localparam int CTL_NLI  = 7;
  localparam int CTL_NEI  = 6;
  localparam int CTL_NLA  = 5;
  localparam int CTL_EA   = 4;
  localparam int CTL_SUB  = 3;
  localparam int CTL_EU   = 2;
  localparam int CTL_NLB  = 1;
  localparam int CTL_NLO  = 0;

  localparam logic [CTL_W-1:0] CTRL_IDLE = 15'h0FE3;

  localparam logic [T_W-1:0] T_F0   = 3'd0;
  localparam logic [T_W-1:0] T_F1   = 3'd1;
  localparam logic [T_W-1:0] T_X0   = 3'd2;
  localparam logic [T_W-1:0] T_X1   = 3'd3;
  localparam logic [T_W-1:0] T_X2   = 3'd4;
  localparam logic [T_W-1:0] T_LAST = 3'd5;

endpackage

// File: rtl/cpu_control_sequencer_decode.sv
// Combinational microcode ROM: (t_state, opcode, flags) -> control word.
// CTRL_EARLY_FETCH_EN moves o_last to each opcode's final busy step.
module cpu_microcode_decode
  import cpu_pkg::*;
(
  input  logic [T_W-1:0]   i_t,
  input  logic [3:0]       i_op,
  input  logic             i_cf,
  input  logic             i_zf,
  output logic [CTL_W-1:0] o_ctl,
  output logic             o_last
);

  logic [T_W-1:0] w_last_t;

  always_comb begin
    o_ctl = CTRL_IDLE;
    unique case (1'b1)
      (i_t == T_F0): begin
        o_ctl[CTL_EP]   = 1'b1;
        o_ctl[CTL_NLMA] = 1'b0;
      end
      (i_t == T_F1): begin
        o_ctl[CTL_NCE] = 1'b0;
        o_ctl[CTL_NLI] = 1'b0;
        o_ctl[CTL_CP]  = 1'b1;
      end
      default: begin
        case (i_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            if (i_t == T_X0) begin
              o_ctl[CTL_NEI]  = 1'b0;
              o_ctl[CTL_NLMA] = 1'b0;
            end else if (i_t == T_X1) begin
              if (i_op == OP_STA) begin
                o_ctl[CTL_EA]   = 1'b1;
                o_ctl[CTL_NLMD] = 1'b0;
              end else begin
                o_ctl[CTL_NCE] = 1'b0;
                o_ctl[CTL_NLA] = i_op != OP_LDA;
                o_ctl[CTL_NLB] = i_op == OP_LDA;
              end
            end else if (i_t == T_X2) begin
              if (i_op == OP_STA) begin
                o_ctl[CTL_NLR] = 1'b0;
              end else if (i_op != OP_LDA) begin
                o_ctl[CTL_EU]  = 1'b1;
                o_ctl[CTL_NLA] = 1'b0;
                o_ctl[CTL_SUB] = i_op == OP_SUB;
              end
            end
          end
          OP_LDI: begin
            if (i_t == T_X0) begin
              o_ctl[CTL_NEI] = 1'b0;
              o_ctl[CTL_NLA] = 1'b0;
            end
          end
          OP_JMP, OP_JC, OP_JZ: begin
            if (i_t == T_X0 &&
                (i_op == OP_JMP ||
                 (i_op == OP_JC && i_cf) ||
                 (i_op == OP_JZ && i_zf))) begin
              o_ctl[CTL_NEI] = 1'b0;
              o_ctl[CTL_LP]  = 1'b1;
            end
          end
          OP_OUT: begin
            if (i_t == T_X0) begin
              o_ctl[CTL_EA]  = 1'b1;
              o_ctl[CTL_NLO] = 1'b0;
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  always_comb begin
`ifdef CTRL_EARLY_FETCH_EN
    case (i_op)
      OP_LDA:                 w_last_t = T_X1;
      OP_ADD, OP_SUB, OP_STA: w_last_t = T_X2;
      OP_HLT:                 w_last_t = T_LAST;
      default:                w_last_t = T_X0;
    endcase
`else
    w_last_t = T_LAST;
`endif
  end

  assign o_last = (i_t == w_last_t);

endmodule

// File: rtl/cpu_control_sequencer.sv
// T-counter, halt latch and reset forcing around the microcode decode.
// Optional CTRL_EARLY_FETCH_EN shortens instructions (see decode).
module cpu_control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        cf,
  input  logic        zf,
  output logic [14:0] control_signals,
  output logic [2:0]  t_state,
  output logic        halted
);

  logic [T_W-1:0]   r_t;
  logic             r_halted;
  logic [CTL_W-1:0] w_ctl;
  logic             w_last;

  cpu_microcode_decode u_dec (
    .i_t    (r_t),
    .i_op   (opcode),
    .i_cf   (cf),
    .i_zf   (zf),
    .o_ctl  (w_ctl),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t      <= T_F0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (r_t == T_X0 && opcode == OP_HLT) begin
        r_halted <= 1'b1;
        r_t      <= T_X1;
      end else if (w_last) begin
        r_t <= T_F0;
      end else begin
        r_t <= r_t + 3'd1;
      end
    end
  end

  // Reset gates the word combinationally so no T0 word leaks out during reset.
  assign control_signals = (!rst_n || r_halted) ? CTRL_IDLE : w_ctl;
  assign t_state         = r_t;
  assign halted          = r_halted;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: directed literal sequences, then random
// opcodes/flags/resets checked every cycle against a micro-op level model.
module tb_cpu_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  opcode = 4'd0;
  logic        cf = 1'b0;
  logic        zf = 1'b0;
  logic [14:0] control_signals;
  logic [2:0]  t_state;
  logic        halted;

  cpu_control_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .opcode          (opcode),
    .cf              (cf),
    .zf              (zf),
    .control_signals (control_signals),
    .t_state         (t_state),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  localparam logic [14:0] IDLE  = 15'h0FE3;
  localparam logic [14:0] M_CP  = 15'h4000;
  localparam logic [14:0] M_EP  = 15'h2000;
  localparam logic [14:0] M_LP  = 15'h1000;
  localparam logic [14:0] M_LMA = 15'h0800;
  localparam logic [14:0] M_LMD = 15'h0400;
  localparam logic [14:0] M_CE  = 15'h0200;
  localparam logic [14:0] M_LR  = 15'h0100;
  localparam logic [14:0] M_LI  = 15'h0080;
  localparam logic [14:0] M_EI  = 15'h0040;
  localparam logic [14:0] M_LA  = 15'h0020;
  localparam logic [14:0] M_EA  = 15'h0010;
  localparam logic [14:0] M_SUB = 15'h0008;
  localparam logic [14:0] M_EU  = 15'h0004;
  localparam logic [14:0] M_LB  = 15'h0002;
  localparam logic [14:0] M_LO  = 15'h0001;

`ifdef CTRL_EARLY_FETCH_EN
  localparam bit EF = 1'b1;
`else
  localparam bit EF = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int m_step = 0;
  bit m_halted = 1'b0;

  // Every micro-op flips its bit away from the idle level.
  function automatic logic [14:0] w(logic [14:0] act);
    return IDLE ^ act;
  endfunction

  function automatic logic [14:0] exp_word(int op, int st, bit h, bit r,
                                           bit c, bit z);
    logic [14:0] fetch_mem;
    if (!r || h) return IDLE;
    if (st == 0) return w(M_EP | M_LMA);
    if (st == 1) return w(M_CP | M_CE | M_LI);
    fetch_mem = w(M_EI | M_LMA);
    case (op)
      1: begin
        if (st == 2) return fetch_mem;
        if (st == 3) return w(M_CE | M_LA);
      end
      2, 3: begin
        if (st == 2) return fetch_mem;
        if (st == 3) return w(M_CE | M_LB);
        if (st == 4) return w(M_EU | M_LA | ((op == 3) ? M_SUB : 15'h0));
      end
      4: begin
        if (st == 2) return fetch_mem;
        if (st == 3) return w(M_EA | M_LMD);
        if (st == 4) return w(M_LR);
      end
      5: if (st == 2) return w(M_EI | M_LA);
      6: if (st == 2) return w(M_EI | M_LP);
      7: if (st == 2 && c) return w(M_EI | M_LP);
      8: if (st == 2 && z) return w(M_EI | M_LP);
      14: if (st == 2) return w(M_EA | M_LO);
      default: ;
    endcase
    return IDLE;
  endfunction

  function automatic int ilen(int op);
    if (!EF) return 6;
    case (op)
      1: return 4;
      2, 3, 4: return 5;
      15: return 6;
      default: return 3;
    endcase
  endfunction

  function automatic int nlen(int k);
    return EF ? k : 6;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_step   <= 0;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (m_step == 2 && opcode == 4'd15) begin
        m_halted <= 1'b1;
        m_step   <= 3;
      end else if (m_step + 1 >= ilen(int'(opcode))) begin
        m_step <= 0;
      end else begin
        m_step <= m_step + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ctl", 32'(control_signals),
          32'(exp_word(int'(opcode), m_step, m_halted, rst_n, cf, zf)));
      chk("m_tstate", 32'(t_state), m_step);
      chk("m_halted", 32'(halted), 32'(m_halted));
    end
  end

  task automatic run(string nm, logic [3:0] op, bit c, bit z, int n,
                     logic [14:0] e2, logic [14:0] e3,
                     logic [14:0] e4, logic [14:0] e5);
    logic [14:0] ex [6];
    ex[0] = 15'h27E3;
    ex[1] = 15'h4D63;
    ex[2] = e2;
    ex[3] = e3;
    ex[4] = e4;
    ex[5] = e5;
    opcode = op;
    cf = c;
    zf = z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_t%0d", nm, i), 32'(control_signals), 32'(ex[i]));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 32'(control_signals), 32'h0FE3);
    chk("rst_t", 32'(t_state), 0);
    chk("rst_h", 32'(halted), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run("nop", 4'd0, 0, 0, nlen(3), IDLE, IDLE, IDLE, IDLE);
    run("lda", 4'd1, 0, 0, nlen(4), 15'h07A3, 15'h0DC3, IDLE, IDLE);
    run("add", 4'd2, 1, 1, nlen(5), 15'h07A3, 15'h0DE1, 15'h0FC7, IDLE);
    run("sub", 4'd3, 0, 1, nlen(5), 15'h07A3, 15'h0DE1, 15'h0FCF, IDLE);
    run("sta", 4'd4, 0, 0, nlen(5), 15'h07A3, 15'h0BF3, 15'h0EE3, IDLE);
    run("ldi", 4'd5, 0, 0, nlen(3), 15'h0F83, IDLE, IDLE, IDLE);
    run("jmp", 4'd6, 0, 0, nlen(3), 15'h1FA3, IDLE, IDLE, IDLE);
    run("jc_t", 4'd7, 1, 0, nlen(3), 15'h1FA3, IDLE, IDLE, IDLE);
    run("jc_n", 4'd7, 0, 1, nlen(3), IDLE, IDLE, IDLE, IDLE);
    run("jz_t", 4'd8, 0, 1, nlen(3), 15'h1FA3, IDLE, IDLE, IDLE);
    run("jz_n", 4'd8, 1, 0, nlen(3), IDLE, IDLE, IDLE, IDLE);
    run("undef", 4'd11, 1, 1, nlen(3), IDLE, IDLE, IDLE, IDLE);
    run("out", 4'd14, 0, 0, nlen(3), 15'h0FF2, IDLE, IDLE, IDLE);
    run("after_out", 4'd0, 0, 0, nlen(3), IDLE, IDLE, IDLE, IDLE);

    run("hlt", 4'd15, 0, 0, 3, IDLE, IDLE, IDLE, IDLE);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hlt_ctl", 32'(control_signals), 32'h0FE3);
      chk("hlt_h", 32'(halted), 1);
      chk("hlt_t", 32'(t_state), 3);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #2;
    chk("hrst_h", 32'(halted), 0);
    chk("hrst_t", 32'(t_state), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    opcode = 4'd0;
    @(negedge clk);
    chk("hrst_t0", 32'(control_signals), 32'h27E3);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4000; i++) begin
      cf = 1'($urandom_range(0, 1));
      zf = 1'($urandom_range(0, 1));
      if (!rst_n) rst_n = 1'b1;
      else if (m_halted ? ($urandom_range(0, 7) == 0)
                        : ($urandom_range(0, 99) == 0)) rst_n = 1'b0;
      else if (m_step == 0) opcode = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
